// File: rtl/spi_ram_pkg.sv
// -----------------------------------------------------------------------------
// spi_ram_pkg
//   Shared constants for the SPI RAM command stream. spi_slave and spi_ram both
//   import this package so the 2-bit command field is decoded identically on
//   both sides of the rx_data/tx_data boundary.
//
//   Contents:
//     DATA_W       : width of one memory word / payload byte (8)
//     DIN_W        : width of one command word from spi_slave (10)
//     CMD_*        : command codes carried in din[9:8]
//     cmd_dec_t    : one-hot decoded command, all-zero when idle
//     decode_cmd() : command word + valid -> cmd_dec_t
// -----------------------------------------------------------------------------
package spi_ram_pkg;

  localparam int DATA_W = 8;
  localparam int DIN_W  = 10;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef struct packed {
    logic wr_addr;
    logic wr_data;
    logic rd_addr;
    logic rd_data;
  } cmd_dec_t;

  // At most one field is set; all-zero means idle (no valid word this cycle).
  function automatic cmd_dec_t decode_cmd(input logic valid, input logic [1:0] cmd);
    cmd_dec_t d;
    d = '0;
    if (valid) begin
      case (cmd)
        CMD_WR_ADDR: d.wr_addr = 1'b1;
        CMD_WR_DATA: d.wr_data = 1'b1;
        CMD_RD_ADDR: d.rd_addr = 1'b1;
        default:     d.rd_data = 1'b1;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/spi_ram_mem.sv
// -----------------------------------------------------------------------------
// spi_ram_mem
//   Bare MEM_DEPTH x DATA_W storage array with one write port and one
//   registered read port. The array itself is not reset; only the read data
//   register is, so the consumer sees 8'h00 out of reset.
//
//   Ports:
//     clk    in  : clock, rising edge
//     rst_n  in  : asynchronous active-low reset (read register only)
//     we     in  : write enable
//     waddr  in  : write address
//     wdata  in  : write data
//     re     in  : read enable; rdata updates on this edge, holds otherwise
//     raddr  in  : read address
//     rdata  out : registered read data
// -----------------------------------------------------------------------------
import spi_ram_pkg::*;

module spi_ram_mem #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] waddr,
  input  logic [DATA_W-1:0]    wdata,
  input  logic                 re,
  input  logic [ADDR_SIZE-1:0] raddr,
  output logic [DATA_W-1:0]    rdata
);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  // Storage has no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register holds its value between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/spi_ram.sv
// -----------------------------------------------------------------------------
// spi_ram
//   Command-driven single-port memory placed after spi_slave. Each valid
//   10-bit word carries a command in din[9:8] and a payload in din[7:0]:
//     00 WR_ADDR : latch write pointer from payload
//     01 WR_DATA : store payload at write pointer
//     10 RD_ADDR : latch read pointer from payload
//     11 RD_DATA : return byte at read pointer on dout, pulse tx_valid
//   Write and read pointers are independent so writes and reads can be
//   interleaved without re-sending addresses. Every command completes on the
//   edge it is sampled; there are no multi-cycle states and no back-pressure.
//
//   Build option:
//     SPI_RAM_AUTOINC_EN : when defined, WR_DATA post-increments the write
//                          pointer and RD_DATA post-increments the read
//                          pointer, both wrapping at MEM_DEPTH-1.
//
//   Ports:
//     clk      in  : clock, rising edge
//     rst_n    in  : asynchronous active-low reset
//     din      in  : command word (rx_data from spi_slave)
//     rx_valid in  : din valid, one command per cycle
//     dout     out : read data (tx_data to spi_slave), holds between reads
//     tx_valid out : dout freshly loaded by RD_DATA this cycle
// -----------------------------------------------------------------------------
import spi_ram_pkg::*;

module spi_ram #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DIN_W-1:0]  din,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid
);

  cmd_dec_t             dec;
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;

  always_comb begin
    dec = decode_cmd(rx_valid, din[DIN_W-1:DATA_W]);
  end

  // Pointers are ADDR_SIZE wide and MEM_DEPTH == 2**ADDR_SIZE, so the
  // increment wraps to 0 naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr  <= '0;
      rd_addr  <= '0;
      tx_valid <= 1'b0;
    end else begin
      tx_valid <= dec.rd_data;
      if (dec.wr_addr) begin
        wr_addr <= din[ADDR_SIZE-1:0];
      end
`ifdef SPI_RAM_AUTOINC_EN
      else if (dec.wr_data) begin
        wr_addr <= wr_addr + ADDR_SIZE'(1);
      end
`endif
      if (dec.rd_addr) begin
        rd_addr <= din[ADDR_SIZE-1:0];
      end
`ifdef SPI_RAM_AUTOINC_EN
      else if (dec.rd_data) begin
        rd_addr <= rd_addr + ADDR_SIZE'(1);
      end
`endif
    end
  end

  spi_ram_mem #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (dec.wr_data),
    .waddr (wr_addr),
    .wdata (din[DATA_W-1:0]),
    .re    (dec.rd_data),
    .raddr (rd_addr),
    .rdata (dout)
  );

endmodule

// File: doc/spi_ram.md
# spi_ram

Single-port synchronous memory that sits directly downstream of `spi_slave`, consuming its 10-bit `rx_data`/`rx_valid` word stream and returning read data on `tx_data`/`tx_valid` for serialization onto MISO. The two top bits of each word select one of four commands: latch write address, write data, latch read address, read data. It holds independent write and read address registers, so the master can interleave writes and reads without re-sending addresses.

## Interface
- `MEM_DEPTH`, 256: number of 8-bit words; must equal 2**ADDR_SIZE.
- `ADDR_SIZE`, 8: address width; legal range 1..8.
- `clk`  input  1: single clock; all state changes on rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `din`  input  10: word from `spi_slave` (`rx_data`); [9:8] command, [7:0] payload.
- `rx_valid`  input  1: `din` is valid this cycle; one command per asserted cycle.
- `dout`  output  8: read data to `spi_slave` (`tx_data`).
- `tx_valid`  output  1: `dout` is valid; single-cycle pulse.

## Operation
- Command encoding `din[9:8]`: 00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA.
- WR_ADDR: `wr_addr <= din[ADDR_SIZE-1:0]`; upper payload bits ignored.
- WR_DATA: `mem[wr_addr] <= din[7:0]`.
- RD_ADDR: `rd_addr <= din[ADDR_SIZE-1:0]`.
- RD_DATA: `dout <= mem[rd_addr]`, `tx_valid` pulses; `din[7:0]` is a dummy byte and ignored.
- `rx_valid` low: no state change except `tx_valid` returning to 0.
- Effective state machine per edge: IDLE (no rx_valid) or execute one command; no multi-cycle states, no back-pressure.
- Reset values: `wr_addr`=0, `rd_addr`=0, `dout`=8'h00, `tx_valid`=0. Memory contents not reset (X in sim until written).
- Reset asserted mid-operation: outputs and address registers clear immediately (asynchronously); a pending `tx_valid` pulse is cancelled.
- `dout` holds its last value after `tx_valid` drops until the next RD_DATA or reset.

## Timing
- All commands take effect on the rising edge where `rx_valid`=1.
- RD_DATA latency: `dout`/`tx_valid` update on the same edge the command is sampled; visible the following cycle; `tx_valid` high exactly one cycle unless RD_DATA repeats on consecutive cycles (then stays high, `dout` updates each cycle).
- Read-after-write: WR_DATA at edge N to address A, RD_DATA at edge N+1 from A returns the new byte.
- WR_ADDR and WR_DATA never coincide (one command per cycle); consecutive WR_DATA without new WR_ADDR rewrite the same address (or next address with autoincrement).

## Configuration
- `SPI_RAM_AUTOINC_EN` defined: after each WR_DATA, `wr_addr` increments; after each RD_DATA, `rd_addr` increments; both wrap from MEM_DEPTH-1 to 0. WR_ADDR/RD_ADDR still overwrite the pointer.
- Not defined: address registers change only on WR_ADDR/RD_ADDR and reset.

## Structure
- Package `spi_ram_pkg`: command localparams `CMD_WR_ADDR`, `CMD_WR_DATA`, `CMD_RD_ADDR`, `CMD_RD_DATA` (2-bit), data width constant 8, `din` width constant 10; shared with `spi_slave` so command decoding stays consistent.
- Sub-module `spi_ram_mem`: bare MEM_DEPTH x 8 array with registered read port and write-enable; `spi_ram` holds command decode, address registers and `tx_valid`.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles -> `dout`=8'h00, `tx_valid`=0; assert reset while `tx_valid`=1 -> drops without waiting for clock.
- Write/read: WR_ADDR 0x2A, WR_DATA 0xD5, RD_ADDR 0x2A, RD_DATA -> next cycle `dout`=0xD5, `tx_valid`=1 for exactly one cycle.
- Independent pointers: WR_ADDR 0x10, RD_ADDR 0x20 pre-loaded 0x77, WR_DATA 0x55, RD_DATA -> `dout`=0x77; then RD_ADDR 0x10, RD_DATA -> 0x55.
- Idle gating: drive `din`=10'h1FF with `rx_valid`=0 for 5 cycles -> memory and pointers unchanged, `tx_valid`=0.
- Autoincrement (macro defined): WR_ADDR 0xFF, WR_DATA 0x11, WR_DATA 0x22 -> mem[0xFF]=0x11, mem[0x00]=0x22; RD_ADDR 0xFF, two RD_DATA -> 0x11 then 0x22, `tx_valid` high two cycles. Without macro -> mem[0xFF]=0x22, reads return 0x22 twice.
- Back-to-back RD_DATA (macro undefined): three consecutive cycles -> `tx_valid` high three cycles, `dout` constant.
